// File: rtl/merge_tree_leaf_fetch_sched_pkg.sv
// Shared types and constants for the merge-tree leaf fetch scheduler.
package merge_tree_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int AXI_BEAT_BYTES     = 64;
  localparam int AXI_BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/merge_tree_leaf_fetch_sched_rr_arbiter.sv
// Round-robin arbiter: scans a doubled request vector from the pointer.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [W:0]     j;

  always_comb begin
    dbl = {req, req};
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (W+1)'(k);
      if (!any && dbl[j]) begin
        any = 1'b1;
        idx = j[W-1:0];
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/merge_tree_leaf_fetch_sched.sv
// Credit-based AR scheduler sharing one AXI read channel among leaf FIFOs.
module merge_tree_leaf_fetch_sched
  import merge_tree_pkg::*;
#(
  parameter int NUM_LEAVES       = 16,
  parameter int BURST_BEATS      = 64,
  parameter int FIFO_DEPTH_BEATS = 256,
  parameter int ADDR_WIDTH       = 64,
  parameter int RUN_BEATS_WIDTH  = 32,
  parameter int MAX_OUTSTANDING  = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  input  logic [ADDR_WIDTH-1:0]         i_stride,
  input  logic [RUN_BEATS_WIDTH-1:0]    i_run_beats,
  input  logic [NUM_LEAVES-1:0]         i_beat_pop,
  input  logic                          i_rlast_hs,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [$clog2(NUM_LEAVES)-1:0] o_ar_leaf,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int LW = $clog2(NUM_LEAVES);
  localparam int CW = $clog2(FIFO_DEPTH_BEATS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int RW = RUN_BEATS_WIDTH;

  sched_state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr [NUM_LEAVES];
  logic [RW-1:0]         rem  [NUM_LEAVES];
  logic [CW-1:0]         cred [NUM_LEAVES];
  logic [RW-1:0]         len  [NUM_LEAVES];
  logic [CW:0]           csum [NUM_LEAVES];
  logic [CW-1:0]         cred_n [NUM_LEAVES];

  logic [OW-1:0]         outstanding;
  logic [LW-1:0]         ptr;
  logic [NUM_LEAVES-1:0] sel;
  logic [NUM_LEAVES-1:0] elig;
  logic [NUM_LEAVES-1:0] nz;
  logic [NUM_LEAVES-1:0] gnt;
  logic [LW-1:0]         gidx;
  logic                  any;
  logic                  hs;
  logic                  load;
  logic [8:0]            blen;

  assign hs   = (state == ISSUE) && m_axi_arready;
  assign load = (state == IDLE) && i_start;
  assign blen = 9'(m_axi_arlen) + 9'd1;

  assign m_axi_arvalid = (state == ISSUE);
  assign o_busy = (state == ARB) || (state == ISSUE) ||
                  (state == DRAIN);
  assign o_done = (state == DONE);

  always_comb begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      len[i] = (rem[i] < RW'(BURST_BEATS)) ?
               rem[i] : RW'(BURST_BEATS);
      nz[i] = (rem[i] != '0);
      elig[i] = nz[i] && (RW'(cred[i]) >= len[i]) &&
                (outstanding < OW'(MAX_OUTSTANDING));
      // Granted burst leaves this cycle while a pop may return one beat.
      csum[i] = {1'b0, cred[i]} + (CW+1)'(i_beat_pop[i]) -
                ((hs && sel[i]) ? (CW+1)'(blen) : '0);
      cred_n[i] = (csum[i] > (CW+1)'(FIFO_DEPTH_BEATS)) ?
                  CW'(FIFO_DEPTH_BEATS) : csum[i][CW-1:0];
    end
  end

  rr_arbiter #(.N(NUM_LEAVES)) u_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (i_start) state_n = ARB;
      ARB: begin
        if (any) state_n = ISSUE;
        else if (nz == '0) state_n = DRAIN;
      end
      ISSUE:   if (m_axi_arready) state_n = ARB;
      DRAIN:   if (outstanding == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_axi_araddr <= '0;
      m_axi_arlen  <= '0;
      o_ar_leaf    <= '0;
      sel          <= '0;
      outstanding  <= '0;
      ptr          <= '0;
      for (int i = 0; i < NUM_LEAVES; i++) begin
        addr[i] <= '0;
        rem[i]  <= '0;
        cred[i] <= CW'(FIFO_DEPTH_BEATS);
      end
    end else begin
      if (state == ARB && any) begin
        m_axi_araddr <= addr[gidx];
        m_axi_arlen  <= 8'(len[gidx] - 1'b1);
        o_ar_leaf    <= gidx;
        sel          <= gnt;
      end
      if (hs) ptr <= o_ar_leaf + 1'b1;
      outstanding <= outstanding + OW'(hs) - OW'(i_rlast_hs);
      for (int i = 0; i < NUM_LEAVES; i++) begin
        if (load) begin
          addr[i] <= i_base_addr + ADDR_WIDTH'(i) * i_stride;
          rem[i]  <= i_run_beats;
          cred[i] <= CW'(FIFO_DEPTH_BEATS);
        end else begin
          if (hs && sel[i]) begin
            addr[i] <= addr[i] + ADDR_WIDTH'(blen) *
                       ADDR_WIDTH'(AXI_BEAT_BYTES);
            rem[i]  <= rem[i] - RW'(blen);
          end
          cred[i] <= cred_n[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_rlast_hs && outstanding == '0))
        else $error("rlast with no burst outstanding");
      for (int i = 0; i < NUM_LEAVES; i++) begin
        assert (!(i_beat_pop[i] && !(hs && sel[i]) &&
                  cred[i] == CW'(FIFO_DEPTH_BEATS)))
          else $error("beat pop at full credit on leaf %0d", i);
      end
    end
  end

endmodule

// File: tb/tb_merge_tree_leaf_fetch_sched.sv
// Directed scoreboard bench for the leaf fetch scheduler (4 leaves).
module tb_merge_tree_leaf_fetch_sched;

  localparam int NL = 4;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] base_addr;
  logic [63:0] stride;
  logic [31:0] run_beats;
  logic [3:0]  pop;
  logic        rlast;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  ar_leaf;
  logic        busy;
  logic        done;

  typedef struct {
    logic [1:0]  leaf;
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t q[$];
  int  npass = 0;
  int  ntot  = 0;

  merge_tree_leaf_fetch_sched #(
    .NUM_LEAVES       (NL),
    .BURST_BEATS      (64),
    .FIFO_DEPTH_BEATS (DEPTH),
    .ADDR_WIDTH       (64),
    .RUN_BEATS_WIDTH  (32),
    .MAX_OUTSTANDING  (32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_base_addr   (base_addr),
    .i_stride      (stride),
    .i_run_beats   (run_beats),
    .i_beat_pop    (pop),
    .i_rlast_hs    (rlast),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .o_ar_leaf     (ar_leaf),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot = ntot + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_rounds(input int run, input int rounds);
    ar_t e;
    for (int b = 0; b < rounds; b++) begin
      for (int i = 0; i < NL; i++) begin
        int l;
        l = run - 64 * b;
        if (l > 64) l = 64;
        if (l > 0) begin
          e.leaf = 2'(i);
          e.addr = 64'h1000 + 64'(i) * 64'h2000 + 64'(b) * 64'h1000;
          e.len  = 8'(l - 1);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic sb_check();
    ar_t e;
    if (q.size() == 0) begin
      chk("ar_unexpected", 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      chk("ar_leaf", 64'(ar_leaf), 64'(e.leaf));
      chk("ar_addr", araddr, e.addr);
      chk("ar_len", 64'(arlen), 64'(e.len));
    end
  endtask

  task automatic start_pass(input int run);
    base_addr = 64'h1000;
    stride    = 64'h2000;
    run_beats = 32'(run);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic collect(input int n);
    int got;
    got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (arvalid && arready) begin
        sb_check();
        got++;
      end
    end
    chk("ar_count", 64'(got), 64'(n));
  endtask

  task automatic quiet(input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (arvalid) cnt++;
    end
    chk("no_extra_ar", 64'(cnt), 64'd0);
  endtask

  task automatic wait_arvalid();
    for (int c = 0; c < 50 && !arvalid; c++) @(negedge clk);
    chk("arvalid_seen", 64'(arvalid), 64'd1);
  endtask

  task automatic rlast_n(input int n);
    repeat (n) begin
      rlast = 1'b1;
      @(negedge clk);
    end
    rlast = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 50 && !done; c++) @(negedge clk);
    chk("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    stride = '0;
    run_beats = '0;
    pop = '0;
    rlast = 1'b0;
    arready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    chk("rst_leaf", 64'(ar_leaf), 64'd0);
    chk("rst_cred", 64'(dut.cred[1]), 64'(DEPTH));
    chk("rst_outst", 64'(dut.outstanding), 64'd0);

    // Full bursts, two rounds.
    push_rounds(128, 2);
    start_pass(128);
    chk("busy_after_start", 64'(busy), 64'd1);
    collect(8);
    chk("busy_draining", 64'(busy), 64'd1);
    rlast_n(7);
    @(negedge clk);
    chk("no_done_early", 64'(done), 64'd0);
    rlast_n(1);
    wait_done();

    // Short tail burst.
    push_rounds(100, 2);
    start_pass(100);
    collect(8);
    rlast_n(8);
    wait_done();

    // Empty run.
    start_pass(0);
    chk("run0_busy", 64'(busy), 64'd1);
    chk("run0_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    chk("run0_done_c2", 64'(done), 64'd0);
    @(negedge clk);
    chk("run0_done_c3", 64'(done), 64'd1);
    chk("run0_arvalid", 64'(arvalid), 64'd0);
    @(negedge clk);
    chk("run0_done_end", 64'(done), 64'd0);
    chk("run0_busy_end", 64'(busy), 64'd0);

    // Back-pressured AR plus same-cycle events.
    arready = 1'b0;
    push_rounds(128, 2);
    start_pass(128);
    for (int a = 0; a < 8; a++) begin
      wait_arvalid();
      sb_check();
      if (a == 0) begin
        repeat (10) begin
          @(negedge clk);
          chk("hold_arvalid", 64'(arvalid), 64'd1);
          chk("hold_addr", araddr, 64'h1000);
          chk("hold_len", 64'(arlen), 64'd63);
          chk("hold_leaf", 64'(ar_leaf), 64'd0);
          chk("hold_cred", 64'(dut.cred[0]), 64'(DEPTH));
          chk("hold_rem", 64'(dut.rem[0]), 64'd128);
        end
      end
      if (a == 2) begin
        chk("outst_pre", 64'(dut.outstanding), 64'd2);
        rlast = 1'b1;
      end
      if (a == 4) begin
        chk("cred_pre", 64'(dut.cred[0]), 64'd64);
        pop = 4'b0001;
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      pop = '0;
      rlast = 1'b0;
      if (a == 0) begin
        chk("hs_cred", 64'(dut.cred[0]), 64'd64);
        chk("hs_rem", 64'(dut.rem[0]), 64'd64);
      end
      if (a == 2) chk("outst_same", 64'(dut.outstanding), 64'd2);
      if (a == 4) chk("cred_pop_hs", 64'(dut.cred[0]), 64'd1);
    end
    arready = 1'b1;
    rlast_n(7);
    wait_done();

    // Credit stall, then release one leaf.
    push_rounds(512, 2);
    start_pass(512);
    collect(8);
    quiet(20);
    chk("stall_busy", 64'(busy), 64'd1);
    begin
      int cnt;
      cnt = 0;
      repeat (64) begin
        pop = 4'b0100;
        @(negedge clk);
        if (arvalid) cnt++;
      end
      pop = '0;
      chk("no_ar_while_pop", 64'(cnt), 64'd0);
    end
    begin
      ar_t e;
      e.leaf = 2'd2;
      e.addr = 64'h7000;
      e.len  = 8'd63;
      q.push_back(e);
    end
    collect(1);
    quiet(20);
    chk("stall_sb_empty", 64'(q.size()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_outst", 64'(dut.outstanding), 64'd0);

    // Reset while an AR is pending.
    arready = 1'b0;
    start_pass(128);
    wait_arvalid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_iss_arvalid", 64'(arvalid), 64'd0);
    chk("rst_iss_busy", 64'(busy), 64'd0);
    chk("rst_iss_addr", araddr, 64'd0);
    arready = 1'b1;
    push_rounds(128, 2);
    start_pass(128);
    collect(8);
    rlast_n(8);
    wait_done();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/merge_tree_leaf_fetch_sched.md
Name: merge_tree_leaf_fetch_sched

Overview:
- Credit-based read scheduler that shares one AXI read-address channel among NUM_LEAVES leaf input buffers of the merge tree.
- Each leaf buffer is a beat FIFO that feeds a per-leaf 512-bit-to-record dispatcher.
- Issues burst requests only when the target leaf FIFO has room reserved for the whole burst, so R data never back-pressures.
- Leaves are served round-robin; the scheduler tracks outstanding bursts to signal pass completion.

Parameters:
- NUM_LEAVES, 16, number of leaf FIFOs (power of 2, 2..64).
- BURST_BEATS, 64, maximum beats per AR burst (1..256; BURST_BEATS*64 must divide 4096).
- FIFO_DEPTH_BEATS, 256, leaf FIFO depth in 512-bit beats (≥ BURST_BEATS).
- ADDR_WIDTH, 64, AXI address width.
- RUN_BEATS_WIDTH, 32, width of the per-leaf run length in beats.
- MAX_OUTSTANDING, 32, maximum in-flight bursts.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_start, in, 1, pulse; launches a pass (honoured only in IDLE).
- i_base_addr, in, ADDR_WIDTH, byte address of leaf 0 run; 64B-aligned.
- i_stride, in, ADDR_WIDTH, byte distance between consecutive leaf runs; multiple of BURST_BEATS*64.
- i_run_beats, in, RUN_BEATS_WIDTH, beats per leaf run; 0 is allowed.
- i_beat_pop, in, NUM_LEAVES, per-leaf one-cycle pulse when that leaf FIFO pops a beat.
- i_rlast_hs, in, 1, R-channel handshake with rlast asserted.
- m_axi_arvalid, out, 1, AR valid.
- m_axi_arready, in, 1, AR ready.
- m_axi_araddr, out, ADDR_WIDTH, AR address.
- m_axi_arlen, out, 8, AR length (beats-1).
- o_ar_leaf, out, log2(NUM_LEAVES), leaf owning the current AR; downstream routing queue pushes this on the AR handshake.
- o_busy, out, 1, high from the accepted i_start until o_done.
- o_done, out, 1, one-cycle pulse at pass completion.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Credits = FIFO_DEPTH_BEATS; remaining = 0; outstanding = 0; RR pointer = 0.
  - Reset mid-operation drops m_axi_arvalid on the next edge. The system resets the AXI side together with this block.
- Per-leaf registers:
  - addr[i] (ADDR_WIDTH).
  - rem[i] (RUN_BEATS_WIDTH).
  - cred[i] (clog2(FIFO_DEPTH_BEATS+1) bits).
- Start (IDLE and i_start):
  - addr[i] = i_base_addr + i*i_stride.
  - rem[i] = i_run_beats.
  - cred[i] = FIFO_DEPTH_BEATS.
  - o_busy=1; go to ARB.
  - i_start in any other state is ignored.
- Burst length: len[i] = min(BURST_BEATS, rem[i]).
- Eligibility: leaf i is eligible iff rem[i]>0, cred[i] ≥ len[i], and outstanding < MAX_OUTSTANDING.
- States:
  - ARB (1 cycle): round-robin pick, starting at pointer, among eligible leaves.
    - Hit: register araddr=addr[g], arlen=len[g]-1, o_ar_leaf=g; go to ISSUE.
    - No hit and all rem==0: go to DRAIN.
    - No hit otherwise: stay in ARB.
  - ISSUE: m_axi_arvalid=1. araddr, arlen and o_ar_leaf are held stable until m_axi_arready. On the handshake:
    - addr[g] += len*64.
    - rem[g] -= len.
    - cred[g] -= len.
    - outstanding++.
    - pointer = g+1 mod NUM_LEAVES.
    - go to ARB.
    - AR rate is therefore at most one per 2 cycles.
  - DRAIN: wait until outstanding==0, then go to DONE.
  - DONE: o_done=1, o_busy=0 for 1 cycle; go to IDLE.
- Credits:
  - cred[i] += 1 on each i_beat_pop[i], every cycle, all leaves in parallel.
  - Pop and grant on the same leaf in the same cycle: cred = cred - len + 1.
  - cred never exceeds FIFO_DEPTH_BEATS; a pop at full credit is a protocol error (assertion, no wrap).
- Outstanding count:
  - decremented on i_rlast_hs.
  - simultaneous AR handshake and i_rlast_hs leaves it unchanged.
  - i_rlast_hs with outstanding==0 is an assertion failure.
- Credits persist across passes only until the next start reload. The next pass must be started only after leaf FIFOs are drained.

Decomposition:
- Package merge_tree_pkg:
  - fsm enum sched_state_t {IDLE, ARB, ISSUE, DRAIN, DONE}.
  - localparam AXI_BEAT_BYTES=64.
  - localparam AXI_BOUNDARY_BYTES=4096.
- Sub-module rr_arbiter #(N):
  - inputs: request vector, pointer.
  - outputs: one-hot grant, grant index, any_grant.
  - purely combinational; a double-width priority scan.

Test Plan:
- NUM_LEAVES=4, BURST=64, DEPTH=256, run_beats=128, base=0x1000, stride=0x2000, arready tied 1, pops disabled:
  - expect 8 ARs in order leaf 0,1,2,3,0,1,2,3.
  - addrs 0x1000, 0x3000, 0x5000, 0x7000, 0x2000, 0x4000, 0x6000, 0x8000.
  - arlen=63 each.
  - after 8 rlast: o_done one cycle.
- run_beats=100:
  - per leaf, first arlen=63, second arlen=35 at addr+0x1000.
- DEPTH=128, BURST=64, run_beats=512, no pops:
  - exactly 2 ARs per leaf, then the scheduler stalls in ARB.
  - pulse i_beat_pop[2] 64 times: exactly one further AR, for leaf 2.
- arready held low 10 cycles during ISSUE:
  - araddr, arlen and o_ar_leaf stable.
  - no credit or rem change until the handshake.
- Same-cycle events:
  - pop and AR handshake on the same leaf (cred 64 → 1): cred=1 after the edge.
  - AR handshake with i_rlast_hs: outstanding unchanged.
- run_beats=0: no ARs; o_done pulses 3 cycles after i_start.
- i_rst during ISSUE:
  - arvalid=0 next cycle; o_busy=0.
  - a subsequent start behaves as fresh.
